// File: rtl/rv_types_pkg.sv
// Shared types for the register-file write-back path.
package rv_types_pkg;

    localparam int unsigned REG_SIZE  = 32;
    localparam int unsigned ADDR_BITS = 5;

    // x0 is hardwired to zero and is never written or tracked as pending.
    localparam logic [ADDR_BITS-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_BITS-1:0] rd;
        logic [REG_SIZE-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries (no bypass, registered full/empty).
module wb_fifo
    import rv_types_pkg::*;
#(
    parameter int unsigned Fifo_depth = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wb_entry_t i_push_data,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);

    localparam int unsigned IdxW = $clog2(Fifo_depth);
    localparam int unsigned PtrW = IdxW + 1;

    wb_entry_t          r_mem [Fifo_depth];
    logic [PtrW-1:0]    r_wr_ptr;
    logic [PtrW-1:0]    r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    // Extra MSB on each pointer tells full from empty when the low bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                       (r_wr_ptr[IdxW-1:0] == r_rd_ptr[IdxW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[IdxW-1:0]];

    // Storage array: written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[IdxW-1:0]] <= i_push_data;
        end
    end

    // Pointer update; reset discards all queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-port owner: ALU/LSU arbitration plus pending-load scoreboard.
// Reg_size and Addr_bits must match the widths in rv_types_pkg.
module reg_writeback_unit
    import rv_types_pkg::*;
#(
    parameter int unsigned Reg_size   = REG_SIZE,
    parameter int unsigned Addr_bits  = ADDR_BITS,
    parameter int unsigned Fifo_depth = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [Addr_bits-1:0]       alu_rd,
    input  logic signed [Reg_size-1:0] alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [Addr_bits-1:0]       mem_rd,
    input  logic signed [Reg_size-1:0] mem_data,
    input  logic                       mark_valid,
    input  logic [Addr_bits-1:0]       mark_rd,
    input  logic [Addr_bits-1:0]       q1,
    input  logic [Addr_bits-1:0]       q2,
    output logic                       hazard,
    output logic                       WE,
    output logic [Addr_bits-1:0]       A3,
    output logic signed [Reg_size-1:0] WD
);

    localparam int unsigned NumRegs = 2 ** Addr_bits;

    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    wb_entry_t                  w_head;
    wb_entry_t                  w_push_data;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_sel_valid;
    wb_entry_t                  w_sel;
    logic [NumRegs-1:0]         w_pending_d;

    logic [NumRegs-1:0]         r_pending;
    logic                       r_we;
    logic [Addr_bits-1:0]       r_a3;
    logic signed [Reg_size-1:0] r_wd;

    // Ready comes straight from registered occupancy, so a pop never raises it same-cycle.
    assign mem_ready        = !w_fifo_full;
    assign w_push           = mem_valid && mem_ready;
    assign w_push_data.rd   = mem_rd;
    assign w_push_data.data = mem_data;

    wb_fifo #(
        .Fifo_depth (Fifo_depth)
    ) u_wb_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    // Write-source selection: ALU has strict priority, otherwise drain the FIFO head.
    always_comb begin
        w_sel       = w_head;
        w_sel_valid = 1'b0;
        w_pop       = 1'b0;
        if (alu_valid) begin
            w_sel.rd    = alu_rd;
            w_sel.data  = alu_data;
            w_sel_valid = 1'b1;
        end else if (!w_fifo_empty) begin
            w_sel_valid = 1'b1;
            w_pop       = 1'b1;
        end
    end

    // Register the selected write; rd=0 is consumed but never enables the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_a3 <= '0;
            r_wd <= '0;
        end else if (w_sel_valid) begin
            r_we <= (w_sel.rd != ZERO_REG);
            r_a3 <= w_sel.rd;
            r_wd <= w_sel.data;
        end else begin
            r_we <= 1'b0;
        end
    end

    // Scoreboard next state: pop clears, then a newer mark on the same rd re-sets it.
    always_comb begin
        w_pending_d = r_pending;
        if (w_pop) begin
            w_pending_d[w_head.rd] = 1'b0;
        end
        if (mark_valid && (mark_rd != ZERO_REG)) begin
            w_pending_d[mark_rd] = 1'b1;
        end
    end

    // Scoreboard register; reset forgets all in-flight loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    assign hazard = ((q1 != ZERO_REG) && r_pending[q1]) ||
                    ((q2 != ZERO_REG) && r_pending[q2]);

    assign WE = r_we;
    assign A3 = r_a3;
    assign WD = r_wd;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: table, directed sequences, random vs queue model.
module tb_reg_writeback_unit;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               alu_valid;
    logic [4:0]         alu_rd;
    logic signed [31:0] alu_data;
    logic               mem_valid;
    logic               mem_ready;
    logic [4:0]         mem_rd;
    logic signed [31:0] mem_data;
    logic               mark_valid;
    logic [4:0]         mark_rd;
    logic [4:0]         q1;
    logic [4:0]         q2;
    logic               hazard;
    logic               WE;
    logic [4:0]         A3;
    logic signed [31:0] WD;

    reg_writeback_unit #(
        .Reg_size   (32),
        .Addr_bits  (5),
        .Fifo_depth (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mark_valid (mark_valid),
        .mark_rd    (mark_rd),
        .q1         (q1),
        .q2         (q2),
        .hazard     (hazard),
        .WE         (WE),
        .A3         (A3),
        .WD         (WD)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of outstanding loads and a pending flag per register.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend[32];
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    bit          m_acc;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
        logic        chk_data;
    } alu_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_haz();
        return ((q1 != 0) && m_pend[q1]) || ((q2 != 0) && m_pend[q2]);
    endfunction

    task automatic model_reset();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_we  = 1'b0;
        m_a3  = '0;
        m_wd  = '0;
        m_acc = 1'b0;
    endtask

    task automatic model_step();
        ent_t e;
        bit   ready;
        ready = (m_q.size() < DEPTH);
        m_acc = mem_valid && ready;
        if (alu_valid) begin
            m_we = (alu_rd != 0);
            m_a3 = alu_rd;
            m_wd = alu_data;
        end else if (m_q.size() != 0) begin
            e = m_q.pop_front();
            m_we = (e.rd != 0);
            m_a3 = e.rd;
            m_wd = e.data;
            m_pend[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (m_acc) begin
            e.rd   = mem_rd;
            e.data = mem_data;
            m_q.push_back(e);
        end
        if (mark_valid && (mark_rd != 0)) m_pend[mark_rd] = 1'b1;
    endtask

    // One clock: advance model at the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        chk("we", WE, m_we);
        chk("a3", A3, m_a3);
        chk("wd", WD, m_wd);
        chk("mem_ready", mem_ready, (m_q.size() < DEPTH));
        chk("hazard", hazard, exp_haz());
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        mem_valid  = 1'b0;
        mem_rd     = '0;
        mem_data   = '0;
        mark_valid = 1'b0;
        mark_rd    = '0;
        q1         = '0;
        q2         = '0;
    endtask

    initial begin
        alu_vec_t vecs[5];

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_we", WE, 1'b0);
        chk("rst_a3", A3, 5'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_ready", mem_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU-only vectors; the idle row checks that A3/WD hold.
        vecs[0] = '{1'b1, 5'd3,  32'hFFFF_FFF9, 1'b1, 5'd3,  32'hFFFF_FFF9, 1'b1};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  32'hFFFF_FFF9, 1'b1};
        vecs[2] = '{1'b1, 5'd31, 32'h7FFF_FFFF, 1'b1, 5'd31, 32'h7FFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 5'd1,  32'h8000_0000, 1'b1, 5'd1,  32'h8000_0000, 1'b1};
        vecs[4] = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         1'b0};
        for (int i = 0; i < 5; i++) begin
            alu_valid = vecs[i].valid;
            alu_rd    = vecs[i].rd;
            alu_data  = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_we", i), WE, vecs[i].exp_we);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_a3", i), A3, vecs[i].exp_a3);
                chk($sformatf("vec%0d_wd", i), WD, vecs[i].exp_wd);
            end
        end
        idle_inputs();
        tick();

        // Priority: ALU held two cycles starves a queued load, then the load drains.
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h11;
        mark_valid = 1'b1; mark_rd = 5'd4; q1 = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h22;
        tick();
        chk("prio_a3_1", A3, 5'd6);
        mem_valid = 1'b0; mark_valid = 1'b0;
        tick();
        chk("prio_a3_2", A3, 5'd6);
        chk("prio_haz_before", hazard, 1'b1);
        alu_valid = 1'b0;
        tick();
        chk("prio_we_3", WE, 1'b1);
        chk("prio_a3_3", A3, 5'd4);
        chk("prio_wd_3", WD, 32'h11);
        chk("prio_haz_after", hazard, 1'b0);
        idle_inputs();
        tick();

        // Full/backpressure: ALU blocks draining while four loads fill the FIFO.
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h99;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'(i + 1);
            tick();
        end
        chk("full_ready0", mem_ready, 1'b0);
        mem_rd = 5'd14; mem_data = 32'd5;
        tick();
        tick();
        chk("full_hold_ready0", mem_ready, 1'b0);
        alu_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (m_acc) mem_valid = 1'b0;
            chk($sformatf("drain%0d_a3", k), A3, 5'(9 + k));
            chk($sformatf("drain%0d_wd", k), WD, 32'(k));
            if (k == 1) chk("drain_ready_after_pop", mem_ready, 1'b1);
        end
        idle_inputs();
        tick();

        // Scoreboard: set, simultaneous clear+set, clear, and rd=0 mark.
        mark_valid = 1'b1; mark_rd = 5'd9; q1 = 5'd9;
        tick();
        chk("sb_haz_set", hazard, 1'b1);
        mark_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hAA;
        tick();
        mem_valid = 1'b0;
        mark_valid = 1'b1; mark_rd = 5'd9;
        tick();
        chk("sb_set_wins", hazard, 1'b1);
        mark_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hBB;
        tick();
        mem_valid = 1'b0;
        tick();
        chk("sb_cleared", hazard, 1'b0);
        q2 = 5'd9;
        #1 chk("sb_q2_clear", hazard, 1'b0);
        mark_valid = 1'b1; mark_rd = 5'd0; q1 = 5'd0; q2 = 5'd0;
        tick();
        mark_valid = 1'b0;
        chk("sb_x0_mark", hazard, 1'b0);
        idle_inputs();

        // x0 load: consumed with WE=0, other pending bits untouched.
        mark_valid = 1'b1; mark_rd = 5'd7; q2 = 5'd7;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
        tick();
        mark_valid = 1'b0; mem_valid = 1'b0;
        tick();
        chk("x0_we", WE, 1'b0);
        chk("x0_haz7", hazard, 1'b1);
        tick();
        chk("x0_empty_ready", mem_ready, 1'b1);
        idle_inputs();

        // Reset mid-stream with three loads queued behind a busy ALU.
        mark_valid = 1'b1; mark_rd = 5'd5; q1 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h3;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(16 + i); mem_data = 32'(100 + i);
            tick();
            mark_valid = 1'b0;
        end
        mem_valid = 1'b0;
        chk("pre_rst_haz", hazard, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_we", WE, 1'b0);
        chk("mid_rst_ready", mem_ready, 1'b1);
        chk("mid_rst_haz", hazard, 1'b0);
        idle_inputs();
        q1 = 5'd5;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_haz", hazard, 1'b0);
        tick();
        tick();
        chk("post_rst_we", WE, 1'b0);

        // Random traffic; LSU obeys valid/ready hold rule.
        m_acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!(mem_valid && !m_acc)) begin
                mem_valid = ($urandom_range(0, 99) < 60);
                mem_rd    = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            alu_valid  = ($urandom_range(0, 99) < 40);
            alu_rd     = 5'($urandom_range(0, 31));
            alu_data   = $urandom;
            mark_valid = ($urandom_range(0, 99) < 30);
            mark_rd    = 5'($urandom_range(0, 7));
            q1         = 5'($urandom_range(0, 7));
            q2         = 5'($urandom_range(0, 7));
            #1 chk("rnd_haz_comb", hazard, exp_haz());
            tick();
        end

        idle_inputs();
        for (int c = 0; c < DEPTH + 2; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Write-side controller for the 3-bus register file: it owns the write port (`WE`, `A3`, `WD`) and arbitrates between the single-cycle ALU result path and the multi-cycle load/store result path. LSU results arrive over a valid/ready handshake and are buffered in a small FIFO. A pending-write scoreboard lets the decode stage detect read-after-write hazards on in-flight loads. The block sits between the execute/memory stages and the register file write port.

## Interface
- `Reg_size`, 32, data width of one register
- `Addr_bits`, 5, register address width (2**Addr_bits registers)
- `Fifo_depth`, 4, LSU result FIFO entries, power of two, ≥2

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle, always accepted
- `alu_rd`  in  Addr_bits  ALU destination register
- `alu_data`  in  Reg_size (signed)  ALU result
- `mem_valid`  in  1  LSU result offered
- `mem_ready`  out  1  FIFO can accept, = !full
- `mem_rd`  in  Addr_bits  LSU destination register
- `mem_data`  in  Reg_size (signed)  LSU load data
- `mark_valid`  in  1  load issued this cycle, set pending bit
- `mark_rd`  in  Addr_bits  destination of the issued load
- `q1`, `q2`  in  Addr_bits  decode-stage source addresses (rs1, rs2)
- `hazard`  out  1  combinational: q1 or q2 pending and non-zero
- `WE`  out  1  register file write enable
- `A3`  out  Addr_bits  register file write address
- `WD`  out  Reg_size (signed)  register file write data

## Operation
- LSU push: `mem_valid && mem_ready` writes {mem_rd, mem_data} at the tail.
- Write selection each cycle: ALU if `alu_valid`; else FIFO head if non-empty (pop); else idle.
- Selected write is registered into `WE/A3/WD`. If the selected rd is 0, `WE`=0 but the entry is still consumed (popped) and x0 stays hardwired zero.
- Idle cycle: `WE`=0; `A3/WD` hold their previous values.
- Scoreboard `pending[2**Addr_bits]`: `mark_valid` sets `pending[mark_rd]` (ignored for rd=0). A FIFO pop clears `pending[rd]` of the popped entry. ALU writes never touch pending.
- Same-cycle set and clear on the same rd: set wins, because a newer load is in flight.
- `hazard` = (q1≠0 && pending[q1]) || (q2≠0 && pending[q2]); a pending bit cleared on this edge stops flagging in the next cycle.
- FIFO full: `mem_ready`=0, and the LSU holds its data (valid/ready rule: data stable while valid && !ready).
- A pop on a full FIFO does not raise `mem_ready` in the same cycle; `mem_ready` depends only on registered occupancy.
- ALU has strict priority, so continuous `alu_valid` starves the FIFO. The pipeline guarantees ALU bubbles; the block does not.

## Timing
- Reset (async assert, sync-style release on `clk`): `WE`=0, `A3`=0, `WD`=0, FIFO empty (`mem_ready`=1), all pending=0.
- Latency: ALU write is seen by the register file at edge N+1 for `alu_valid` at edge N. An LSU push at edge N with an empty FIFO and no ALU write gives `WE` at edge N+2.
- Throughput: one register write per cycle; one push per cycle.
- Simultaneous push and pop: occupancy unchanged. Push onto an empty FIFO is never popped in the same cycle (no bypass).
- Pointers: log2(Fifo_depth)+1 bits, wrap-around; full = MSBs differ and low bits equal.
- Reset mid-operation discards FIFO contents and pending bits; in-flight loads must be re-issued upstream.

## Structure
- Shared package `rv_types_pkg`: `wb_entry_t` struct {rd, data} and `ZERO_REG` constant.
- Sub-module `wb_fifo` (synchronous FIFO of `wb_entry_t`, params Fifo_depth; ports push/pop/full/empty/head). The scoreboard and arbitration stay in the top module.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with 3 entries queued → `WE`=0, `mem_ready`=1, `hazard`=0 for q1=5 after release.
- ALU only: `alu_valid`, rd=3, data=-7 → next edge `WE`=1, `A3`=3, `WD`=32'hFFFF_FFF9.
- Priority: FIFO holds {rd=4, 0x11}, and `alu_valid` {rd=6, 0x22} is held 2 cycles → writes rd6, rd6, then rd4; `pending[4]` clears after rd4 is written.
- Full/backpressure: push 4 LSU entries with `alu_valid`=1 held → `mem_ready`=0 after the 4th; 5th data stays held; after ALU drops, entries drain in order 1–4, then the 5th is accepted.
- Scoreboard: mark rd=9, q1=9 → `hazard`=1; pop rd=9 and mark rd=9 in the same cycle → `hazard` stays 1; mark rd=0 → no hazard.
- x0: LSU entry rd=0 → popped, `WE`=0, and any pending state for other registers is unchanged.
